// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every bus-facing signal of mem_port_arbiter: the fetch request
//   port, the load/store request port and the single CPU memory bus.
//   modport slave  : the arbiter's view (requests and memory responses in,
//                    completions and memory requests out).
//   modport master : the environment's view (requesters plus memory system).
interface mem_port_arbiter_if;
    // Instruction fetch port
    logic        FetchReq;
    logic [31:0] FetchAddr;
    logic [31:0] FetchData;
    logic        FetchDone;
    logic        FetchError;
    // Load/store port
    logic        DataReq;
    logic        DataWrite;
    logic [31:0] DataAddr;
    logic [31:0] DataWdata;
    logic [1:0]  DataWidth;
    logic        DataSignExtend;
    logic [31:0] DataRdata;
    logic        DataDone;
    logic        DataError;
    // Memory bus
    logic [31:0] MemAddr;
    logic [31:0] MemWdata;
    logic        MemReadAssert;
    logic        MemWriteAssert;
    logic [31:0] MemRData;
    logic        MemReadOK;
    logic        MemWriteOK;

    modport slave (
        input  FetchReq, FetchAddr,
        input  DataReq, DataWrite, DataAddr, DataWdata, DataWidth, DataSignExtend,
        input  MemRData, MemReadOK, MemWriteOK,
        output FetchData, FetchDone, FetchError,
        output DataRdata, DataDone, DataError,
        output MemAddr, MemWdata, MemReadAssert, MemWriteAssert
    );

    modport master (
        output FetchReq, FetchAddr,
        output DataReq, DataWrite, DataAddr, DataWdata, DataWidth, DataSignExtend,
        output MemRData, MemReadOK, MemWriteOK,
        input  FetchData, FetchDone, FetchError,
        input  DataRdata, DataDone, DataError,
        input  MemAddr, MemWdata, MemReadAssert, MemWriteAssert
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one word-wide memory bus between instruction fetch and core
//   load/store. Round-robin arbitration on ties, sub-word load lane select
//   with sign/zero extension, and read-modify-write for byte/half stores
//   (the memory has no byte enables).
// Ports:
//   CoreClock   : clock, all state on the rising edge
//   CoreResetN  : asynchronous active-low reset
//   bus         : mem_port_arbiter_if.slave (fetch port, data port, memory bus)
// Parameters:
//   TIMEOUT_CYCLES : wait-state cycles before an access is aborted
// Build option:
//   ARB_TIMEOUT_EN : when defined, a 16-bit wait counter aborts accesses that
//                    see no ReadOK/WriteOK within TIMEOUT_CYCLES cycles.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              CoreClock,
    input  logic              CoreResetN,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, FETCH_RD, DATA_RD, DATA_WR, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t      state_q, state_d;
    logic        last_data_q, last_data_d;   // 1: data port won the last grant
    logic        who_data_q, who_data_d;     // owner of the access in flight
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  width_q, width_d;
    logic        sext_q, sext_d;
    logic [15:0] wlo_q, wlo_d;               // store data needed by the RMW merge
    logic [31:0] res_q, res_d;
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rd_q, rd_d, wr_q, wr_d;
    logic [31:0] fetch_data_q, fetch_data_d, data_rdata_q, data_rdata_d;
    logic        fetch_done_q, fetch_done_d, fetch_err_q, fetch_err_d;
    logic        data_done_q, data_done_d, data_err_q, data_err_d;
    logic        fetch_elig, data_elig, grant_data, data_bad;

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        tmo_hit;
    assign tmo_hit = (tmo_q >= 16'(TIMEOUT_CYCLES - 1));
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Right-justify the addressed lane and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  width,
                                                input logic        sext);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] r;
        b  = word[{lane, 3'b000} +: 8];
        h  = lane[1] ? word[31:16] : word[15:0];
        sb = b;
        sh = h;
        r  = word;
        case (width)
            2'b00: begin
                if (sext) r = sb;
                else      r = {24'h0, b};
            end
            2'b01: begin
                if (sext) r = sh;
                else      r = {16'h0, h};
            end
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte/half of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  width,
                                                input logic [15:0] wlo);
        logic [31:0] r;
        r = word;
        if (width == 2'b00)  r[{lane, 3'b000} +: 8] = wlo[7:0];
        else if (lane[1])    r[31:16] = wlo;
        else                 r[15:0]  = wlo;
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        who_data_d   = who_data_q;
        lane_d       = lane_q;
        width_d      = width_q;
        sext_d       = sext_q;
        wlo_d        = wlo_q;
        res_d        = res_q;
        err_d        = err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        fetch_data_d = 32'h0;
        fetch_done_d = 1'b0;
        fetch_err_d  = 1'b0;
        data_rdata_d = 32'h0;
        data_done_d  = 1'b0;
        data_err_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        tmo_d        = tmo_q;
`endif
        // A requester still showing its Done pulse is finishing; do not re-grant it.
        fetch_elig = bus.FetchReq && !fetch_done_q;
        data_elig  = bus.DataReq && !data_done_q;
        grant_data = data_elig && (!fetch_elig || !last_data_q);
        data_bad   = (bus.DataWidth == 2'b11) ||
                     (bus.DataWidth == 2'b01 && bus.DataAddr[0]) ||
                     (bus.DataWidth == 2'b10 && bus.DataAddr[1:0] != 2'b00);

        case (state_q)
            IDLE: begin
                if (fetch_elig || data_elig) begin
                    last_data_d = grant_data;
                    who_data_d  = grant_data;
                    res_d       = 32'h0;
                    err_d       = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    tmo_d       = 16'h0;
`endif
                    if (!grant_data) begin
                        if (bus.FetchAddr[1:0] != 2'b00) begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end else begin
                            mem_addr_d = {bus.FetchAddr[31:2], 2'b00};
                            rd_d       = 1'b1;
                            state_d    = FETCH_RD;
                        end
                    end else begin
                        lane_d  = bus.DataAddr[1:0];
                        width_d = bus.DataWidth;
                        sext_d  = bus.DataSignExtend;
                        wlo_d   = bus.DataWdata[15:0];
                        if (data_bad) begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end else begin
                            mem_addr_d = {bus.DataAddr[31:2], 2'b00};
                            if (!bus.DataWrite) begin
                                rd_d    = 1'b1;
                                state_d = DATA_RD;
                            end else if (bus.DataWidth == 2'b10) begin
                                mem_wdata_d = bus.DataWdata;
                                wr_d        = 1'b1;
                                state_d     = DATA_WR;
                            end else begin
                                rd_d    = 1'b1;
                                state_d = RMW_RD;
                            end
                        end
                    end
                end
            end
            FETCH_RD, DATA_RD, RMW_RD: begin
                if (bus.MemReadOK) begin
                    rd_d = 1'b0;
                    if (state_q == RMW_RD) begin
                        mem_wdata_d = store_merge(bus.MemRData, lane_q, width_q, wlo_q);
                        wr_d        = 1'b1;
                        state_d     = RMW_WR;
                    end else begin
                        res_d   = (state_q == FETCH_RD) ? bus.MemRData
                                : load_extend(bus.MemRData, lane_q, width_q, sext_q);
                        state_d = RESP;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    rd_d    = 1'b0;
                    err_d   = 1'b1;
                    res_d   = 32'h0;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            DATA_WR, RMW_WR: begin
                if (bus.MemWriteOK) begin
                    wr_d    = 1'b0;
                    state_d = RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
`endif
            end
            RESP: begin
                if (who_data_q) begin
                    data_done_d  = 1'b1;
                    data_rdata_d = res_q;
                    data_err_d   = err_q;
                end else begin
                    fetch_done_d = 1'b1;
                    fetch_data_d = res_q;
                    fetch_err_d  = err_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CoreClock or negedge CoreResetN) begin
        if (!CoreResetN) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b1;
            who_data_q   <= 1'b0;
            lane_q       <= 2'b00;
            width_q      <= 2'b00;
            sext_q       <= 1'b0;
            wlo_q        <= 16'h0;
            res_q        <= 32'h0;
            err_q        <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            fetch_data_q <= 32'h0;
            fetch_done_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            data_rdata_q <= 32'h0;
            data_done_q  <= 1'b0;
            data_err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q        <= 16'h0;
`endif
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            who_data_q   <= who_data_d;
            lane_q       <= lane_d;
            width_q      <= width_d;
            sext_q       <= sext_d;
            wlo_q        <= wlo_d;
            res_q        <= res_d;
            err_q        <= err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            fetch_data_q <= fetch_data_d;
            fetch_done_q <= fetch_done_d;
            fetch_err_q  <= fetch_err_d;
            data_rdata_q <= data_rdata_d;
            data_done_q  <= data_done_d;
            data_err_q   <= data_err_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q        <= tmo_d;
`endif
        end
    end

    assign bus.FetchData      = fetch_data_q;
    assign bus.FetchDone      = fetch_done_q;
    assign bus.FetchError     = fetch_err_q;
    assign bus.DataRdata      = data_rdata_q;
    assign bus.DataDone       = data_done_q;
    assign bus.DataError      = data_err_q;
    assign bus.MemAddr        = mem_addr_q;
    assign bus.MemWdata       = mem_wdata_q;
    assign bus.MemReadAssert  = rd_q;
    assign bus.MemWriteAssert = wr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed and randomized checks of mem_port_arbiter against a word-memory
//   reference model. A behavioural memory answers MemReadAssert/MemWriteAssert
//   after a programmable number of wait cycles.
module tb_mem_port_arbiter;
    localparam int TMO = 4;

    logic clk;
    logic rst_n;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .CoreClock  (clk),
        .CoreResetN (rst_n),
        .bus        (bus)
    );

    int vectors;
    int miscompares;

    // Memory environment state
    bit [31:0] mem     [bit [31:0]];
    bit [31:0] ref_mem [bit [31:0]];
    int          rd_wait, wr_wait;
    bit          mem_hang;
    int          rd_cnt, wr_cnt;
    int          n_rd_cyc, n_wr_cyc;
    int          n_both_assert, n_both_done, n_misalign;
    logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural memory and bus monitor, acting on the falling edge.
    initial begin
        rd_cnt = 0; wr_cnt = 0; n_rd_cyc = 0; n_wr_cyc = 0;
        n_both_assert = 0; n_both_done = 0; n_misalign = 0;
        last_rd_addr = 32'h0; last_wr_addr = 32'h0; last_wr_data = 32'h0;
        bus.MemReadOK = 1'b0; bus.MemWriteOK = 1'b0; bus.MemRData = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.MemReadAssert && bus.MemWriteAssert) n_both_assert++;
            if (bus.FetchDone && bus.DataDone) n_both_done++;
            if ((bus.MemReadAssert || bus.MemWriteAssert) && bus.MemAddr[1:0] != 2'b00) n_misalign++;
            if (bus.MemReadAssert) begin
                n_rd_cyc++;
                if (!mem_hang && rd_cnt >= rd_wait) begin
                    bus.MemReadOK = 1'b1;
                    bus.MemRData  = mem.exists(bus.MemAddr) ? mem[bus.MemAddr] : 32'h0;
                    last_rd_addr  = bus.MemAddr;
                    rd_cnt        = 0;
                end else begin
                    bus.MemReadOK = 1'b0;
                    bus.MemRData  = $urandom;
                    rd_cnt++;
                end
            end else begin
                bus.MemReadOK = 1'b0;
                bus.MemRData  = $urandom;
                rd_cnt        = 0;
            end
            if (bus.MemWriteAssert) begin
                n_wr_cyc++;
                if (!mem_hang && wr_cnt >= wr_wait) begin
                    bus.MemWriteOK    = 1'b1;
                    mem[bus.MemAddr]  = bus.MemWdata;
                    last_wr_addr      = bus.MemAddr;
                    last_wr_data      = bus.MemWdata;
                    wr_cnt            = 0;
                end else begin
                    bus.MemWriteOK = 1'b0;
                    wr_cnt++;
                end
            end else begin
                bus.MemWriteOK = 1'b0;
                wr_cnt         = 0;
            end
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Load result from plain arithmetic on the old word.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] width, input bit sext);
        longint v;
        int unsigned sh;
        if (width == 2'd2) return word;
        sh = (addr % 4) * 8;
        if (width == 2'd0) begin
            v = longint'((word >> sh) % 256);
            if (sext && v >= 128) v = v - 256;
        end else begin
            v = longint'((word >> sh) % 65536);
            if (sext && v >= 32768) v = v - 65536;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [1:0] width, input logic [31:0] wdata);
        logic [31:0] mask;
        int unsigned sh;
        sh   = (addr % 4) * 8;
        mask = ((width == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        return (old & ~mask) | ((wdata << sh) & mask);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One complete request on either port, checked against the model.
    task automatic run_op(input string tag, input bit is_fetch, input bit wr,
                          input logic [31:0] addr, input logic [1:0] width, input bit sext,
                          input logic [31:0] wdata, input int rw, input int ww);
        logic [31:0] waddr, old, exp_data, exp_wdata, obs_data;
        bit          valid, obs_err, done, do_rd, do_wr;
        int          lat, cnt, rc0, wc0;
        waddr = addr & 32'hFFFF_FFFC;
        old   = ref_rd(waddr);
        if (is_fetch) valid = (addr % 4 == 0);
        else          valid = (width != 2'd3) && !(width == 2'd1 && addr % 2 != 0) &&
                              !(width == 2'd2 && addr % 4 != 0);
        do_rd = valid && (is_fetch || !wr || width != 2'd2);
        do_wr = valid && !is_fetch && wr;
        exp_data = 32'h0;
        if (valid && is_fetch) exp_data = old;
        else if (valid && !wr) exp_data = ref_load(old, addr, width, sext);
        exp_wdata = (width == 2'd2) ? wdata : ref_merge(old, addr, width, wdata);
        if (do_wr) ref_mem[waddr] = exp_wdata;
        lat = 2 + (do_rd ? rw + 1 : 0) + (do_wr ? ww + 1 : 0);

        rd_wait = rw; wr_wait = ww;
        rc0 = n_rd_cyc; wc0 = n_wr_cyc;
        if (is_fetch) begin
            bus.FetchReq = 1'b1; bus.FetchAddr = addr;
        end else begin
            bus.DataReq = 1'b1; bus.DataWrite = wr; bus.DataAddr = addr;
            bus.DataWidth = width; bus.DataSignExtend = sext; bus.DataWdata = wdata;
        end
        cnt = 0; done = 1'b0;
        while (!done && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            done = is_fetch ? bus.FetchDone : bus.DataDone;
        end
        obs_data = is_fetch ? bus.FetchData : bus.DataRdata;
        obs_err  = is_fetch ? bus.FetchError : bus.DataError;
        bus.FetchReq = 1'b0; bus.DataReq = 1'b0;

        check({tag, " done"},     32'(done), 32'd1);
        check({tag, " latency"},  32'(cnt), 32'(lat));
        check({tag, " rdata"},    obs_data, exp_data);
        check({tag, " error"},    32'(obs_err), 32'(!valid));
        check({tag, " rd_cycles"}, 32'(n_rd_cyc - rc0), do_rd ? 32'(rw + 1) : 32'd0);
        check({tag, " wr_cycles"}, 32'(n_wr_cyc - wc0), do_wr ? 32'(ww + 1) : 32'd0);
        if (do_rd) check({tag, " rd_addr"}, last_rd_addr, waddr);
        if (do_wr) begin
            check({tag, " wr_addr"}, last_wr_addr, waddr);
            check({tag, " wr_data"}, last_wr_data, exp_wdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " MemAddr"},  bus.MemAddr, 32'h0);
        check({tag, " MemWdata"}, bus.MemWdata, 32'h0);
        check({tag, " asserts"},  {30'h0, bus.MemReadAssert, bus.MemWriteAssert}, 32'h0);
        check({tag, " dones"},    {28'h0, bus.FetchDone, bus.FetchError, bus.DataDone, bus.DataError}, 32'h0);
        check({tag, " FetchData"}, bus.FetchData, 32'h0);
        check({tag, " DataRdata"}, bus.DataRdata, 32'h0);
    endtask

    initial begin
        int          order[$];
        int          cnt, kind, rw, ww, rc0;
        logic [31:0] a, wd;
        logic [1:0]  w;
        bit          s, wr;

        vectors = 0; miscompares = 0;
        rst_n = 1'b0; rd_wait = 0; wr_wait = 0; mem_hang = 1'b0;
        bus.FetchReq = 1'b0; bus.FetchAddr = 32'h0;
        bus.DataReq = 1'b0; bus.DataWrite = 1'b0; bus.DataAddr = 32'h0;
        bus.DataWdata = 32'h0; bus.DataWidth = 2'b00; bus.DataSignExtend = 1'b0;

        mem[32'h104] = 32'hDEAD_BEEF; ref_mem[32'h104] = 32'hDEAD_BEEF;
        mem[32'h200] = 32'h8011_2233; ref_mem[32'h200] = 32'h8011_2233;
        mem[32'h300] = 32'h1122_3344; ref_mem[32'h300] = 32'h1122_3344;
        for (int i = 0; i < 8; i++) begin
            wd = $urandom;
            mem[32'h1000 + 32'(4 * i)] = wd;
            ref_mem[32'h1000 + 32'(4 * i)] = wd;
        end

        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("fetch basic",    1'b1, 1'b0, 32'h104, 2'd2, 1'b0, 32'h0, 2, 0);
        run_op("byte load sx",   1'b0, 1'b0, 32'h203, 2'd0, 1'b1, 32'h0, 1, 0);
        run_op("byte load zx",   1'b0, 1'b0, 32'h203, 2'd0, 1'b0, 32'h0, 0, 0);
        run_op("half load sx",   1'b0, 1'b0, 32'h202, 2'd1, 1'b1, 32'h0, 0, 0);
        run_op("half store rmw", 1'b0, 1'b1, 32'h302, 2'd1, 1'b0, 32'h0000_ABCD, 1, 1);
        check("rmw result word", mem_rd(32'h300), 32'hABCD_3344);
        run_op("word store",     1'b0, 1'b1, 32'h300, 2'd2, 1'b0, 32'h5A5A_0F0F, 0, 2);
        run_op("store misalign", 1'b0, 1'b1, 32'h401, 2'd2, 1'b0, 32'h1234_5678, 0, 0);
        run_op("width illegal",  1'b0, 1'b0, 32'h400, 2'd3, 1'b0, 32'h0, 0, 0);
        run_op("fetch misalign", 1'b1, 1'b0, 32'h002, 2'd2, 1'b0, 32'h0, 0, 0);

        // Both requesters held continuously from reset: strict alternation.
        rst_n = 1'b0; rd_wait = 0; wr_wait = 0;
        bus.FetchReq = 1'b1; bus.FetchAddr = 32'h104;
        bus.DataReq = 1'b1; bus.DataWrite = 1'b0; bus.DataAddr = 32'h200;
        bus.DataWidth = 2'd2; bus.DataSignExtend = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        while (order.size() < 4 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (bus.FetchDone) order.push_back(0);
            if (bus.DataDone)  order.push_back(1);
        end
        bus.FetchReq = 1'b0; bus.DataReq = 1'b0;
        check("rr done count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("rr grant order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i % 2));
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            a    = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            w    = 2'($urandom_range(0, 3));
            s    = 1'($urandom_range(0, 1));
            wr   = (kind == 2);
            wd   = $urandom;
            rw   = $urandom_range(0, 3);
            ww   = $urandom_range(0, 3);
            if (kind == 0) begin
                if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            end else if ($urandom_range(0, 4) == 0) begin
                a = a + 32'($urandom_range(1, 3));
            end else if (w == 2'd0) begin
                a = a + 32'($urandom_range(0, 3));
            end else if (w == 2'd1) begin
                a = a + 32'(2 * $urandom_range(0, 1));
            end
            run_op("random op", kind == 0, wr, a, w, s, wd, rw, ww);
        end
        for (int i = 0; i < 8; i++)
            check("final memory", mem_rd(32'h1000 + 32'(4 * i)), ref_rd(32'h1000 + 32'(4 * i)));

`ifdef ARB_TIMEOUT_EN
        // No ReadOK ever: the load must abort with an error after TMO wait cycles.
        mem_hang = 1'b1;
        rc0 = n_rd_cyc;
        bus.DataReq = 1'b1; bus.DataWrite = 1'b0; bus.DataAddr = 32'h1000;
        bus.DataWidth = 2'd2; bus.DataSignExtend = 1'b0;
        cnt = 0;
        while (!bus.DataDone && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("timeout done",    32'(bus.DataDone), 32'd1);
        check("timeout latency", 32'(cnt), 32'(TMO + 2));
        check("timeout error",   32'(bus.DataError), 32'd1);
        check("timeout rdata",   bus.DataRdata, 32'h0);
        check("timeout rd_cycles", 32'(n_rd_cyc - rc0), 32'(TMO));
        bus.DataReq = 1'b0;
        mem_hang = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
`endif

        // Asynchronous reset while an RMW write is waiting for WriteOK.
        rd_wait = 0; wr_wait = 50;
        bus.DataReq = 1'b1; bus.DataWrite = 1'b1; bus.DataAddr = 32'h1006;
        bus.DataWidth = 2'd1; bus.DataWdata = 32'h0000_5555; bus.DataSignExtend = 1'b0;
        cnt = 0;
        while (!bus.MemWriteAssert && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("rmw reached write", 32'(bus.MemWriteAssert), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("async reset");
        bus.DataReq = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("aborted rmw word", mem_rd(32'h1004), ref_rd(32'h1004));

        check("both asserts high", 32'(n_both_assert), 32'd0);
        check("both dones high",   32'(n_both_done), 32'd0);
        check("misaligned MemAddr", 32'(n_misalign), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
